// File: rtl/rpn_exec_pkg.sv
// rtl/rpn_exec_pkg.sv - opcodes, error codes, stack commands and FSM states for rpn_exec
// Purpose: shared definitions for rpn_exec and rpn_alu.
// Config macro: RPN_MUL_EN makes opcode 9 (MUL) a legal binary operator.
package rpn_exec_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] RPN_PUSH = 4'd0;
  localparam logic [OPW-1:0] RPN_ADD  = 4'd1;
  localparam logic [OPW-1:0] RPN_SUB  = 4'd2;
  localparam logic [OPW-1:0] RPN_AND  = 4'd3;
  localparam logic [OPW-1:0] RPN_OR   = 4'd4;
  localparam logic [OPW-1:0] RPN_XOR  = 4'd5;
  localparam logic [OPW-1:0] RPN_NEG  = 4'd6;
  localparam logic [OPW-1:0] RPN_DUP  = 4'd7;
  localparam logic [OPW-1:0] RPN_DROP = 4'd8;
  localparam logic [OPW-1:0] RPN_MUL  = 4'd9;

  localparam logic [1:0] RPN_ERR_NONE    = 2'd0;
  localparam logic [1:0] RPN_ERR_UNDER   = 2'd1;
  localparam logic [1:0] RPN_ERR_OVER    = 2'd2;
  localparam logic [1:0] RPN_ERR_ILLEGAL = 2'd3;

  // Stack command codes shared with the operand stack.
  localparam int SC_N = 2;
  localparam logic [SC_N-1:0] SC_NOP = 2'd0;
  localparam logic [SC_N-1:0] SC_PUS = 2'd1;
  localparam logic [SC_N-1:0] SC_POP = 2'd2;
  localparam logic [SC_N-1:0] SC_TOP = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_POP1, S_POP2, S_CAP, S_PUSH} state_t;

  function automatic logic op_is_binary(input logic [OPW-1:0] op);
    case (op)
      RPN_ADD, RPN_SUB, RPN_AND, RPN_OR, RPN_XOR: op_is_binary = 1'b1;
`ifdef RPN_MUL_EN
      RPN_MUL: op_is_binary = 1'b1;
`endif
      default: op_is_binary = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_legal(input logic [OPW-1:0] op);
    op_is_legal = (op <= RPN_DROP) || op_is_binary(op);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// rtl/rpn_alu.sv - combinational result generator for rpn_exec
// Purpose: computes the value pushed at the end of an op.
// Ports: op_i opcode, a_i deeper operand (or immediate / single operand),
//        b_i top operand, result_o value to push (modulo 2^N).
// Config macro: RPN_MUL_EN adds the MUL operator (low N bits of a*b).
module rpn_alu
  import rpn_exec_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [OPW-1:0] op_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [N-1:0]   result_o
);

  // PUSH and DUP fall through to default: the value to push already sits in a_i.
  always_comb begin
    result_o = a_i;
    case (op_i)
      RPN_ADD: result_o = a_i + b_i;
      RPN_SUB: result_o = a_i - b_i;
      RPN_AND: result_o = a_i & b_i;
      RPN_OR:  result_o = a_i | b_i;
      RPN_XOR: result_o = a_i ^ b_i;
      RPN_NEG: result_o = -a_i;
`ifdef RPN_MUL_EN
      RPN_MUL: result_o = a_i * b_i;
`endif
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/rpn_exec.sv
// rtl/rpn_exec.sv - RPN token sequencer driving the shared operand stack
// Purpose: accepts one RPN token at a time, issues SC_* stack commands,
//          tracks depth, flags errors and mirrors top-of-stack.
// Ports: Clock/Reset (async active-low); op_valid/op_ready/op_code/op_imm token
//        handshake; cmd stack command; data shared tri-state bus (driven only
//        in PUSH); depth entry count; tos_valid/tos top mirror; err sticky
//        error code; err_clr synchronous clear.
// Config macro: RPN_MUL_EN enables opcode 9 (MUL).
module rpn_exec
  import rpn_exec_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 64,
  parameter int DW    = 7
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [OPW-1:0]  op_code,
  input  logic [N-1:0]    op_imm,
  output logic [SC_N-1:0] cmd,
  inout  wire  [N-1:0]    data,
  output logic [DW-1:0]   depth,
  output logic            tos_valid,
  output logic [N-1:0]    tos,
  output logic [1:0]      err,
  input  logic            err_clr
);

  localparam logic [DW-1:0] ONE  = DW'(1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [N-1:0]   tos_q, tos_d;
  logic           tv_q, tv_d;
  logic [1:0]     err_q, err_d;
  logic [1:0]     pre_err;
  logic [N-1:0]   alu_res;
  logic           drive_bus;

  rpn_alu #(.N(N)) u_alu (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res)
  );

  // Checked against the depth before the op; a failing token is consumed in IDLE.
  always_comb begin
    pre_err = RPN_ERR_NONE;
    if (!op_is_legal(op_code))
      pre_err = RPN_ERR_ILLEGAL;
    else if (op_is_binary(op_code)) begin
      if (depth_q < DW'(2)) pre_err = RPN_ERR_UNDER;
    end else if (op_code != RPN_PUSH && depth_q == '0)
      pre_err = RPN_ERR_UNDER;
    else if ((op_code == RPN_PUSH || op_code == RPN_DUP) && depth_q == FULL)
      pre_err = RPN_ERR_OVER;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (op_valid && pre_err == RPN_ERR_NONE)
                state_d = (op_code == RPN_PUSH) ? S_PUSH : S_POP1;
      S_POP1: state_d = op_is_binary(op_q) ? S_POP2 : S_CAP;
      S_POP2: state_d = S_CAP;
      S_CAP:  state_d = (op_q == RPN_DROP) ? S_IDLE : S_PUSH;
      S_PUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CAP is always NOP, so PUS never follows POP/TOP while the stack still drives.
  always_comb begin
    op_ready  = 1'b0;
    cmd       = SC_NOP;
    drive_bus = 1'b0;
    case (state_q)
      S_IDLE: op_ready = 1'b1;
      S_POP1: cmd = (op_q == RPN_DUP) ? SC_TOP : SC_POP;
      S_POP2: cmd = SC_POP;
      S_PUSH: begin
        cmd       = SC_PUS;
        drive_bus = 1'b1;
      end
      default: ;
    endcase
  end

  assign data = drive_bus ? alu_res : {N{1'bz}};

  // POP2 sees the top (B) on the bus, CAP sees the next entry (A) or the lone operand.
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    depth_d = depth_q;
    tos_d   = tos_q;
    tv_d    = tv_q;
    err_d   = err_q;
    if (err_clr) err_d = RPN_ERR_NONE;
    case (state_q)
      S_IDLE: if (op_valid) begin
        if (pre_err != RPN_ERR_NONE) err_d = pre_err;
        else begin
          op_d = op_code;
          a_d  = op_imm;
        end
      end
      S_POP2: b_d = data;
      S_CAP: begin
        a_d = data;
        if (op_q == RPN_DROP) begin
          depth_d = depth_q - ONE;
          tv_d    = 1'b0;
        end
      end
      S_PUSH: begin
        tos_d = alu_res;
        tv_d  = 1'b1;
        if (op_q == RPN_PUSH || op_q == RPN_DUP) depth_d = depth_q + ONE;
        else if (op_is_binary(op_q))             depth_d = depth_q - ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q    <= RPN_PUSH;
      a_q     <= '0;
      b_q     <= '0;
      depth_q <= '0;
      tos_q   <= '0;
      tv_q    <= 1'b0;
      err_q   <= RPN_ERR_NONE;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      depth_q <= depth_d;
      tos_q   <= tos_d;
      tv_q    <= tv_d;
      err_q   <= err_d;
    end
  end

  assign depth     = depth_q;
  assign tos       = tos_q;
  assign tos_valid = tv_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rpn_exec.sv
// tb/tb_rpn_exec.sv - scoreboard testbench for rpn_exec with a behavioural stack
module tb_rpn_exec;
  import rpn_exec_pkg::*;

  localparam int N = 16;
  localparam int DEPTH = 64;
  localparam int DW = 7;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic op_valid = 1'b0;
  logic err_clr = 1'b0;
  logic [3:0] op_code = '0;
  logic [N-1:0] op_imm = '0;
  logic op_ready, tos_valid;
  logic [SC_N-1:0] cmd;
  logic [DW-1:0] depth;
  logic [N-1:0] tos;
  logic [1:0] err;
  wire [N-1:0] data;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clock = ~Clock;

  rpn_exec #(.N(N), .DEPTH(DEPTH), .DW(DW)) dut (
    .Clock(Clock), .Reset(Reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm), .cmd(cmd), .data(data), .depth(depth),
    .tos_valid(tos_valid), .tos(tos), .err(err), .err_clr(err_clr)
  );

  // Behavioural stack: POP/TOP data appears the cycle after the command and
  // stays on the bus until a non-POP/TOP command is clocked.
  logic [N-1:0] smem [0:DEPTH-1];
  int sp;
  logic stk_drv;
  logic [N-1:0] stk_bus;
  assign data = stk_drv ? stk_bus : {N{1'bz}};

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sp <= 0; stk_drv <= 1'b0; stk_bus <= '0;
    end else begin
      case (cmd)
        SC_PUS: begin
          if (sp < DEPTH) smem[sp] <= data;
          sp <= sp + 1; stk_drv <= 1'b0;
        end
        SC_POP: begin
          if (sp > 0) stk_bus <= smem[sp-1];
          sp <= sp - 1; stk_drv <= 1'b1;
        end
        SC_TOP: begin
          if (sp > 0) stk_bus <= smem[sp-1];
          stk_drv <= 1'b1;
        end
        default: stk_drv <= 1'b0;
      endcase
    end
  end

  // Reference model state and scoreboard.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] ref_q[$];
  logic [1:0] ref_err = 2'd0;
  logic ref_tv = 1'b0;
  logic [SC_N-1:0] cmd_log[$];
  int busy_cycles = 0, nonnop_cnt = 0, conflict_cnt = 0;

  always @(negedge Clock) begin
    if (Reset) begin
      if (!op_ready) begin busy_cycles++; cmd_log.push_back(cmd); end
      if (cmd != SC_NOP) nonnop_cnt++;
      if (stk_drv && cmd == SC_PUS) conflict_cnt++;
      if (cmd == SC_PUS) begin
        total_cnt++;
        if (exp_q.size() == 0)
          $display("FAIL push_data: unexpected PUS data=%0h, no push expected", data);
        else begin
          logic [N-1:0] e;
          e = exp_q.pop_front();
          if (data !== e) $display("FAIL push_data: data=%0h expected %0h", data, e);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic model_op(input logic [3:0] c, input logic [N-1:0] imm);
    logic [N-1:0] a, b, r;
    bit bin;
    bin = (c >= 4'd1 && c <= 4'd5);
`ifdef RPN_MUL_EN
    if (c == 4'd9) bin = 1'b1;
`endif
    if (bin) begin
      if (ref_q.size() < 2) ref_err = 2'd1;
      else begin
        b = ref_q.pop_back(); a = ref_q.pop_back();
        case (c)
          4'd1: r = a + b;
          4'd2: r = a - b;
          4'd3: r = a & b;
          4'd4: r = a | b;
          4'd5: r = a ^ b;
          default: r = a * b;
        endcase
        ref_q.push_back(r); exp_q.push_back(r); ref_tv = 1'b1;
      end
    end else begin
      case (c)
        4'd0: if (ref_q.size() == DEPTH) ref_err = 2'd2;
              else begin ref_q.push_back(imm); exp_q.push_back(imm); ref_tv = 1'b1; end
        4'd6: if (ref_q.size() < 1) ref_err = 2'd1;
              else begin a = ref_q.pop_back(); r = -a; ref_q.push_back(r); exp_q.push_back(r); ref_tv = 1'b1; end
        4'd7: if (ref_q.size() < 1) ref_err = 2'd1;
              else if (ref_q.size() == DEPTH) ref_err = 2'd2;
              else begin r = ref_q[$]; ref_q.push_back(r); exp_q.push_back(r); ref_tv = 1'b1; end
        4'd8: if (ref_q.size() < 1) ref_err = 2'd1;
              else begin a = ref_q.pop_back(); ref_tv = 1'b0; end
        default: ref_err = 2'd3;
      endcase
    end
  endtask

  task automatic send_op(input logic [3:0] c, input logic [N-1:0] imm, input logic clr);
    int n = 0;
    while (!op_ready && n < 50) begin @(negedge Clock); n++; end
    if (!op_ready) begin
      total_cnt++;
      $display("FAIL send_op_timeout: op_ready=%0b expected 1", op_ready);
    end
    op_valid = 1'b1; op_code = c; op_imm = imm; err_clr = clr;
    @(negedge Clock);
    op_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!op_ready && n < 50) begin @(negedge Clock); n++; end
    if (!op_ready) begin
      total_cnt++;
      $display("FAIL wait_idle_timeout: op_ready=%0b expected 1", op_ready);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [N-1:0] imm);
    model_op(c, imm);
    send_op(c, imm, 1'b0);
    wait_idle();
  endtask

  task automatic do_reset();
    Reset = 1'b0; op_valid = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge Clock);
    exp_q.delete(); ref_q.delete(); ref_err = 2'd0; ref_tv = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt += 6;
    if (cmd !== SC_NOP) $display("FAIL rst_cmd: got %0d expected %0d", cmd, SC_NOP); else pass_cnt++;
    if (op_ready !== 1'b1) $display("FAIL rst_ready: got %0b expected 1", op_ready); else pass_cnt++;
    if (depth !== 7'd0) $display("FAIL rst_depth: got %0d expected 0", depth); else pass_cnt++;
    if (tos_valid !== 1'b0) $display("FAIL rst_tos_valid: got %0b expected 0", tos_valid); else pass_cnt++;
    if (tos !== 16'd0) $display("FAIL rst_tos: got %0h expected 0", tos); else pass_cnt++;
    if (err !== 2'd0) $display("FAIL rst_err: got %0d expected 0", err); else pass_cnt++;
  endtask

  task automatic test_sub();
    logic [SC_N-1:0] exp_cmds [6];
    exp_cmds = '{SC_PUS, SC_PUS, SC_POP, SC_POP, SC_NOP, SC_PUS};
    cmd_log.delete();
    issue(RPN_PUSH, 16'd5); issue(RPN_PUSH, 16'd3); issue(RPN_SUB, 16'd0);
    total_cnt++;
    if (cmd_log.size() != 6) $display("FAIL sub_cmd_len: got %0d expected 6", cmd_log.size()); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (i >= cmd_log.size()) $display("FAIL sub_cmd[%0d]: missing expected %0d", i, exp_cmds[i]);
      else if (cmd_log[i] !== exp_cmds[i]) $display("FAIL sub_cmd[%0d]: got %0d expected %0d", i, cmd_log[i], exp_cmds[i]);
      else pass_cnt++;
    end
    total_cnt += 3;
    if (depth !== 7'd1) $display("FAIL sub_depth: got %0d expected 1", depth); else pass_cnt++;
    if (tos !== 16'd2) $display("FAIL sub_tos: got %0h expected 2", tos); else pass_cnt++;
    if (tos_valid !== 1'b1) $display("FAIL sub_tos_valid: got %0b expected 1", tos_valid); else pass_cnt++;
  endtask

  task automatic test_underflow();
    nonnop_cnt = 0;
    issue(RPN_ADD, 16'd0);
    repeat (2) @(negedge Clock);
    total_cnt += 3;
    if (err !== 2'd1) $display("FAIL uf_err: got %0d expected 1", err); else pass_cnt++;
    if (nonnop_cnt !== 0) $display("FAIL uf_cmds: got %0d non-NOP cmds expected 0", nonnop_cnt); else pass_cnt++;
    if (depth !== 7'd1) $display("FAIL uf_depth: got %0d expected 1", depth); else pass_cnt++;
    err_clr = 1'b1; @(negedge Clock); err_clr = 1'b0; ref_err = 2'd0;
    total_cnt++;
    if (err !== 2'd0) $display("FAIL uf_clr: got %0d expected 0", err); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    conflict_cnt = 0;
    for (int i = 0; i < DEPTH; i++) issue(RPN_PUSH, N'($urandom));
    total_cnt++;
    if (depth !== 7'd64) $display("FAIL of_full_depth: got %0d expected 64", depth); else pass_cnt++;
    issue(RPN_PUSH, 16'hABCD);
    total_cnt += 2;
    if (err !== 2'd2) $display("FAIL of_push_err: got %0d expected 2", err); else pass_cnt++;
    if (depth !== 7'd64) $display("FAIL of_push_depth: got %0d expected 64", depth); else pass_cnt++;
    err_clr = 1'b1; @(negedge Clock); err_clr = 1'b0;
    issue(RPN_DUP, 16'd0);
    total_cnt += 3;
    if (err !== 2'd2) $display("FAIL of_dup_err: got %0d expected 2", err); else pass_cnt++;
    if (depth !== 7'd64) $display("FAIL of_dup_depth: got %0d expected 64", depth); else pass_cnt++;
    if (tos !== ref_q[$]) $display("FAIL of_tos: got %0h expected %0h", tos, ref_q[$]); else pass_cnt++;
    issue(RPN_XOR, 16'd0);
    total_cnt += 2;
    if (depth !== 7'd63) $display("FAIL of_xor_depth: got %0d expected 63", depth); else pass_cnt++;
    if (conflict_cnt !== 0) $display("FAIL of_bus_conflict: got %0d cycles expected 0", conflict_cnt); else pass_cnt++;
  endtask

  task automatic test_neg_dup_xor();
    do_reset();
    busy_cycles = 0;
    issue(RPN_PUSH, 16'h8000); issue(RPN_NEG, 16'd0); issue(RPN_DUP, 16'd0); issue(RPN_XOR, 16'd0);
    total_cnt += 4;
    if (busy_cycles !== 11) $display("FAIL ndx_cycles: got %0d expected 11", busy_cycles); else pass_cnt++;
    if (tos !== 16'd0) $display("FAIL ndx_tos: got %0h expected 0", tos); else pass_cnt++;
    if (depth !== 7'd1) $display("FAIL ndx_depth: got %0d expected 1", depth); else pass_cnt++;
    if (tos_valid !== 1'b1) $display("FAIL ndx_tos_valid: got %0b expected 1", tos_valid); else pass_cnt++;
  endtask

  task automatic test_drop_illegal();
    do_reset();
    issue(RPN_PUSH, 16'h1234); issue(RPN_DROP, 16'd0);
    total_cnt += 2;
    if (tos_valid !== 1'b0) $display("FAIL drop_tos_valid: got %0b expected 0", tos_valid); else pass_cnt++;
    if (depth !== 7'd0) $display("FAIL drop_depth: got %0d expected 0", depth); else pass_cnt++;
    issue(RPN_DROP, 16'd0);
    total_cnt++;
    if (err !== 2'd1) $display("FAIL drop_uf_err: got %0d expected 1", err); else pass_cnt++;
    // clear and a new error in the same cycle: the new code wins
    model_op(4'd15, 16'd0); send_op(4'd15, 16'd0, 1'b1); wait_idle();
    total_cnt++;
    if (err !== 2'd3) $display("FAIL illegal_err: got %0d expected 3", err); else pass_cnt++;
  endtask

  task automatic test_mul();
    logic [1:0] e_err;
    logic [DW-1:0] e_depth;
    do_reset();
    issue(RPN_PUSH, 16'd300); issue(RPN_PUSH, 16'd300); issue(RPN_MUL, 16'd0);
`ifdef RPN_MUL_EN
    e_err = 2'd0; e_depth = 7'd1;
`else
    e_err = 2'd3; e_depth = 7'd2;
`endif
    total_cnt += 3;
    if (err !== e_err) $display("FAIL mul_err: got %0d expected %0d", err, e_err); else pass_cnt++;
    if (depth !== e_depth) $display("FAIL mul_depth: got %0d expected %0d", depth, e_depth); else pass_cnt++;
    if (tos !== ref_q[$]) $display("FAIL mul_tos: got %0h expected %0h", tos, ref_q[$]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(RPN_PUSH, 16'd1); issue(RPN_PUSH, 16'd2);
    send_op(RPN_ADD, 16'd0, 1'b0);
    @(negedge Clock);
    total_cnt++;
    if (cmd !== SC_POP) $display("FAIL mid_pop2_cmd: got %0d expected %0d", cmd, SC_POP); else pass_cnt++;
    Reset = 1'b0;
    #1;
    total_cnt += 3;
    if (cmd !== SC_NOP) $display("FAIL mid_rst_cmd: got %0d expected %0d", cmd, SC_NOP); else pass_cnt++;
    if (depth !== 7'd0) $display("FAIL mid_rst_depth: got %0d expected 0", depth); else pass_cnt++;
    if (op_ready !== 1'b1) $display("FAIL mid_rst_ready: got %0b expected 1", op_ready); else pass_cnt++;
    @(negedge Clock);
    exp_q.delete(); ref_q.delete(); ref_err = 2'd0; ref_tv = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    issue(RPN_PUSH, 16'h0077);
    total_cnt += 2;
    if (tos !== 16'h0077) $display("FAIL mid_after_tos: got %0h expected 77", tos); else pass_cnt++;
    if (depth !== 7'd1) $display("FAIL mid_after_depth: got %0d expected 1", depth); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] c;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (ref_q.size() < 2 || $urandom_range(0, 2) == 0) c = RPN_PUSH;
      else c = 4'($urandom_range(1, 9));
      issue(c, N'($urandom));
      total_cnt += 3;
      if (depth !== DW'(ref_q.size())) $display("FAIL b2b_depth[%0d]: got %0d expected %0d", i, depth, ref_q.size()); else pass_cnt++;
      if (err !== ref_err) $display("FAIL b2b_err[%0d]: got %0d expected %0d", i, err, ref_err); else pass_cnt++;
      if (tos_valid !== ref_tv) $display("FAIL b2b_tv[%0d]: got %0b expected %0b", i, tos_valid, ref_tv); else pass_cnt++;
      if (ref_tv) begin
        total_cnt++;
        if (tos !== ref_q[$]) $display("FAIL b2b_tos[%0d]: got %0h expected %0h", i, tos, ref_q[$]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_underflow();
    test_overflow();
    test_neg_dup_xor();
    test_drop_illegal();
    test_mul();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge Clock);
    total_cnt += 2;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d pushes outstanding expected 0", exp_q.size()); else pass_cnt++;
    if (conflict_cnt !== 0) $display("FAIL bus_conflict: got %0d cycles expected 0", conflict_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
